// File: rtl/core_defs_pkg.sv
// ---------------------------------------------------------------------------
// core_defs
//   Shared definitions for the multi-cycle RISC-V core: decode ALU op codes,
//   sequencing-FSM state encoding and small decode helpers. Decode, ALU and
//   control all import this package so the encodings have one source.
// ---------------------------------------------------------------------------
package core_defs;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD     = 4'b0000,
        OP_ADDI    = 4'b0001,
        OP_LOAD    = 4'b0010,
        OP_STORE   = 4'b0011,
        OP_LUI     = 4'b0100,
        OP_JUMP    = 4'b0101,
        OP_OR      = 4'b0110,
        OP_AND     = 4'b0111,
        OP_BRANCH  = 4'b1000,
        OP_SUB     = 4'b1001,
        OP_INVALID = 4'b1111
    } alu_op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEMORY    = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_FAULT     = 3'b111
    } ctrl_state_e;

    // Ops that need a data-memory access after EXECUTE.
    function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles a memory request has been waiting for mem_ready and flags
//   a timeout on the cycle the count would reach MEM_TIMEOUT.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   clr_i      clear the count (no request pending, or request completed)
//   inc_i      request pending and not ready this cycle
//   timeout_o  this waiting cycle is the MEM_TIMEOUT-th in a row
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    // The count only ever holds 0 .. MEM_TIMEOUT-1.
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // A ready in the limit cycle deasserts inc_i, so it is a success.
    assign timeout_o = inc_i && (cnt_q == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i || timeout_o) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main sequencing FSM of the multi-cycle RISC-V core:
//   FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH,
//   with a sticky FAULT state for invalid ops and memory stall timeouts.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   alu_op            decode ALU op (core_defs::alu_op_e encoding)
//   dec_we            decode register-write request
//   dec_mem_write     decode store request
//   dec_branch_en     decode branch/jump flag (redirects follow alu_op)
//   alu_zero          branch compare result, valid in EXECUTE
//   mem_ready         memory completes the current request this cycle
//   ir_we, pc_we      instruction register / PC write strobes
//   pc_src            0 = PC+4, 1 = branch/jump target
//   rf_we             register-file write strobe
//   mem_req, mem_wr   memory request valid / request is a write
//   mem_is_fetch      request addresses the PC (1) or ALU result (0)
//   fault             sticky fault flag
//   state_o           current state encoding (debug)
//   retired           instructions completed since reset, wraps
// ---------------------------------------------------------------------------
module multicycle_control
    import core_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                dec_we,
    input  logic                dec_mem_write,
    input  logic                dec_branch_en,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_src,
    output logic                rf_we,
    output logic                mem_req,
    output logic                mem_wr,
    output logic                mem_is_fetch,
    output logic                fault,
    output logic [STATE_W-1:0]  state_o,
    output logic [RETIRE_W-1:0] retired
);

    ctrl_state_e         state_q;
    logic [RETIRE_W-1:0] retired_q;

    logic req_waiting;
    logic req_clear;
    logic wait_timeout;

    // Redirect decisions come from alu_op; the decode flag is redundant here.
    logic unused_branch_en;
    assign unused_branch_en = dec_branch_en;

    // Clearing whenever no request is outstanding (or one just completed)
    // guarantees a zero count on every entry to FETCH or MEMORY.
    assign req_waiting = mem_req & ~mem_ready;
    assign req_clear   = ~mem_req | mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (req_clear),
        .inc_i     (req_waiting),
        .timeout_o (wait_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (wait_timeout) begin
                        state_q <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    if (alu_op == OP_INVALID) begin
                        state_q <= ST_FAULT;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (alu_op == OP_BRANCH) begin
                        state_q   <= ST_FETCH;
                        retired_q <= retired_q + RETIRE_W'(1);
                    end else if (is_mem_op(alu_op)) begin
                        state_q <= ST_MEMORY;
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        if (alu_op == OP_STORE) begin
                            state_q   <= ST_FETCH;
                            retired_q <= retired_q + RETIRE_W'(1);
                        end else begin
                            state_q <= ST_WRITEBACK;
                        end
                    end else if (wait_timeout) begin
                        state_q <= ST_FAULT;
                    end
                end
                ST_WRITEBACK: begin
                    state_q   <= ST_FETCH;
                    retired_q <= retired_q + RETIRE_W'(1);
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    // Moore decode of state; FETCH strobes follow mem_ready and EXECUTE
    // redirects follow the decode inputs. Everything is held low while rst
    // is asserted so an abandoned instruction cannot update PC or RF.
    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        rf_we        = 1'b0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_is_fetch = 1'b0;
        fault        = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_we        = mem_ready;
                    pc_we        = mem_ready;
                end
                ST_EXECUTE: begin
                    if (alu_op == OP_BRANCH) begin
                        pc_we  = alu_zero;
                        pc_src = alu_zero;
                    end else if (alu_op == OP_JUMP) begin
                        pc_we  = 1'b1;
                        pc_src = 1'b1;
                    end
                end
                ST_MEMORY: begin
                    mem_req = 1'b1;
                    mem_wr  = dec_mem_write;
                end
                ST_WRITEBACK: begin
                    rf_we = dec_we;
                end
                ST_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Each instruction is expanded into
//   the per-cycle output sequence its phases must produce; a single compare
//   process checks every cycle, and literal counts/values pin the expansion.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned RETIRE_W    = 4;

    localparam logic [2:0] S_FETCH  = 3'b000;
    localparam logic [2:0] S_DECODE = 3'b001;
    localparam logic [2:0] S_EXEC   = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB     = 3'b100;
    localparam logic [2:0] S_FAULT  = 3'b111;

    localparam logic [3:0] ADD = 4'b0000, ADDI = 4'b0001, LOAD = 4'b0010;
    localparam logic [3:0] STORE = 4'b0011, LUI = 4'b0100, JUMP = 4'b0101;
    localparam logic [3:0] OR_ = 4'b0110, AND_ = 4'b0111, BRANCH = 4'b1000;
    localparam logic [3:0] SUB = 4'b1001, INVALID = 4'b1111;
    localparam logic [3:0] ALU_TBL [5] = '{ADDI, LUI, OR_, AND_, SUB};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] alu_op = '0;
    logic dec_we = 1'b0, dec_mem_write = 1'b0, dec_branch_en = 1'b0;
    logic alu_zero = 1'b0, mem_ready = 1'b0;
    logic ir_we, pc_we, pc_src, rf_we, mem_req, mem_wr, mem_is_fetch, fault;
    logic [2:0] state_o;
    logic [RETIRE_W-1:0] retired;

    multicycle_control #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .RETIRE_W   (RETIRE_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_op        (alu_op),
        .dec_we        (dec_we),
        .dec_mem_write (dec_mem_write),
        .dec_branch_en (dec_branch_en),
        .alu_zero      (alu_zero),
        .mem_ready     (mem_ready),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .rf_we         (rf_we),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_is_fetch  (mem_is_fetch),
        .fault         (fault),
        .state_o       (state_o),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]          st;
        logic                ir_we, pc_we, pc_src, rf_we;
        logic                mem_req, mem_wr, mem_is_fetch, fault;
        logic [RETIRE_W-1:0] ret;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    exp_t exp_q[$];
    lit_t lit_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [RETIRE_W-1:0] m_ret = '0;
    logic [3:0]  p_op = '0;
    logic        p_we = 1'b0, p_mw = 1'b0, p_zero = 1'b0;
    bit          p_first = 1'b0;
    int unsigned n_cyc, n_ir, n_pc, n_rf, n_dreq, n_wr;
    logic [31:0] s_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: per-cycle expectations plus literal checks.
    exp_t ce;
    lit_t cl;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("state", 32'(state_o), 32'(ce.st));
            chk("ir_we", 32'(ir_we), 32'(ce.ir_we));
            chk("pc_we", 32'(pc_we), 32'(ce.pc_we));
            chk("rf_we", 32'(rf_we), 32'(ce.rf_we));
            chk("mem_req", 32'(mem_req), 32'(ce.mem_req));
            chk("fault", 32'(fault), 32'(ce.fault));
            chk("retired", 32'(retired), 32'(ce.ret));
            if (ce.pc_we) chk("pc_src", 32'(pc_src), 32'(ce.pc_src));
            if (ce.mem_req) begin
                chk("mem_wr", 32'(mem_wr), 32'(ce.mem_wr));
                chk("mem_is_fetch", 32'(mem_is_fetch), 32'(ce.mem_is_fetch));
            end
        end
        while (lit_q.size() != 0) begin
            cl = lit_q.pop_front();
            chk(cl.name, cl.act, cl.exp);
        end
    end

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st = st;
        e.ir_we = 1'b0; e.pc_we = 1'b0; e.pc_src = 1'b0; e.rf_we = 1'b0;
        e.mem_req = 1'b0; e.mem_wr = 1'b0; e.mem_is_fetch = 1'b0; e.fault = 1'b0;
        e.ret = m_ret;
        return e;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] x);
        lit_t l;
        l.name = n; l.act = a; l.exp = x;
        lit_q.push_back(l);
    endtask

    // One clock cycle: drive inputs after the edge, queue its expectation,
    // then tally what the DUT showed mid-cycle.
    task automatic cyc(input logic rdy, input exp_t e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (p_first) begin
            alu_op        = p_op;
            dec_we        = p_we;
            dec_mem_write = p_mw;
            dec_branch_en = (p_op == BRANCH) || (p_op == JUMP);
            alu_zero      = p_zero;
        end
        mem_ready = rdy;
        exp_q.push_back(e);
        @(negedge clk);
        if (p_first) s_ret = 32'(retired);
        p_first = 1'b0;
        n_cyc++;
        if (ir_we) n_ir++;
        if (pc_we) n_pc++;
        if (rf_we) n_rf++;
        if (mem_req && !mem_is_fetch) n_dreq++;
        if (mem_req && mem_wr) n_wr++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready = rnd();
        m_ret = '0;
        exp_q.push_back(mk(S_FETCH));
        @(negedge clk);
    endtask

    task automatic fault_tail();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e = mk(S_FAULT);
            e.fault = 1'b1;
            cyc(rnd(), e);
        end
    endtask

    // Expands one instruction into its phases: fetch (with fwait stall
    // cycles), decode, execute, optional memory (mwait stalls), writeback.
    task automatic run_instr(input logic [3:0] op, input logic we, input logic mw,
                             input logic zero, input int unsigned fwait,
                             input int unsigned mwait, input bit abort_mem);
        exp_t e;
        p_op = op; p_we = we; p_mw = mw; p_zero = zero; p_first = 1'b1;
        n_cyc = 0; n_ir = 0; n_pc = 0; n_rf = 0; n_dreq = 0; n_wr = 0;
        for (int unsigned w = 0; w < fwait && w < MEM_TIMEOUT; w++) begin
            e = mk(S_FETCH); e.mem_req = 1'b1; e.mem_is_fetch = 1'b1;
            cyc(1'b0, e);
        end
        if (fwait >= MEM_TIMEOUT) begin
            fault_tail();
            return;
        end
        e = mk(S_FETCH); e.mem_req = 1'b1; e.mem_is_fetch = 1'b1;
        e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = 1'b0;
        cyc(1'b1, e);
        cyc(rnd(), mk(S_DECODE));
        if (op == INVALID) begin
            fault_tail();
            return;
        end
        e = mk(S_EXEC);
        if (op == BRANCH) begin
            e.pc_we = zero; e.pc_src = zero;
            cyc(rnd(), e);
            m_ret++;
            return;
        end
        if (op == JUMP) begin
            e.pc_we = 1'b1; e.pc_src = 1'b1;
        end
        cyc(rnd(), e);
        if (op == LOAD || op == STORE) begin
            for (int unsigned w = 0; w < mwait && w < MEM_TIMEOUT; w++) begin
                if (abort_mem && w == 2) begin
                    apply_reset();
                    return;
                end
                e = mk(S_MEM); e.mem_req = 1'b1; e.mem_wr = mw;
                cyc(1'b0, e);
            end
            if (mwait >= MEM_TIMEOUT) begin
                fault_tail();
                return;
            end
            e = mk(S_MEM); e.mem_req = 1'b1; e.mem_wr = mw;
            cyc(1'b1, e);
            if (op == STORE) begin
                m_ret++;
                return;
            end
        end
        e = mk(S_WB); e.rf_we = we;
        cyc(rnd(), e);
        m_ret++;
    endtask

    initial begin
        apply_reset();
        lit("reset_retired", 32'(retired), 32'd0);
        lit("reset_state", 32'(state_o), 32'd0);

        run_instr(ADD, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        lit("add_cycles", n_cyc, 32'd4);
        lit("add_ir_pulses", n_ir, 32'd1);
        lit("add_rf_pulses", n_rf, 32'd1);

        run_instr(LOAD, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0);
        lit("add_retired", s_ret, 32'd1);
        lit("load_cycles", n_cyc, 32'd8);
        lit("load_data_req_cycles", n_dreq, 32'd4);
        lit("load_write_cycles", n_wr, 32'd0);
        lit("load_rf_pulses", n_rf, 32'd1);

        run_instr(BRANCH, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        lit("load_retired", s_ret, 32'd2);
        lit("br_taken_pc_we", n_pc, 32'd2);
        lit("br_taken_cycles", n_cyc, 32'd3);

        run_instr(BRANCH, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        lit("br_taken_retired", s_ret, 32'd3);
        lit("br_not_taken_pc_we", n_pc, 32'd1);

        run_instr(STORE, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0);
        lit("two_branch_retired", s_ret, 32'd4);
        lit("store_write_cycles", n_wr, 32'd3);
        lit("store_rf_pulses", n_rf, 32'd0);
        lit("store_cycles", n_cyc, 32'd7);

        run_instr(JUMP, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        lit("store_retired", s_ret, 32'd5);
        lit("jump_pc_we", n_pc, 32'd2);
        lit("jump_rf_pulses", n_rf, 32'd1);
        lit("jump_cycles", n_cyc, 32'd4);

        for (int i = 0; i < 11; i++) begin
            run_instr(ALU_TBL[i % 5], 1'(i % 2), 1'b0, 1'(i % 3 == 0),
                      32'(i % 3), 0, 1'b0);
        end

        // Both stalls end on the last allowed cycle: success, counter wrapped.
        run_instr(LOAD, 1'b1, 1'b0, 1'b0, 15, 15, 1'b0);
        lit("wrap_retired", s_ret, 32'd1);
        lit("limit_load_cycles", n_cyc, 32'd35);
        lit("limit_no_fault", 32'(fault), 32'd0);

        run_instr(LOAD, 1'b1, 1'b0, 1'b0, 0, 16, 1'b0);
        lit("limit_load_retired", s_ret, 32'd2);
        lit("mem_timeout_fault", 32'(fault), 32'd1);
        lit("mem_timeout_state", 32'(state_o), 32'd7);
        lit("mem_timeout_retired", 32'(retired), 32'd2);

        apply_reset();
        lit("reset_clears_fault", 32'(fault), 32'd0);
        lit("reset_clears_retired", 32'(retired), 32'd0);

        run_instr(ADD, 1'b1, 1'b0, 1'b0, MEM_TIMEOUT, 0, 1'b0);
        lit("fetch_timeout_cycles", n_cyc, 32'd21);
        lit("fetch_timeout_fault", 32'(fault), 32'd1);
        lit("fetch_timeout_ir", n_ir, 32'd0);

        apply_reset();
        run_instr(ADD, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(INVALID, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        lit("invalid_state", 32'(state_o), 32'd7);
        lit("invalid_retired", 32'(retired), 32'd1);
        lit("invalid_cycles", n_cyc, 32'd7);

        apply_reset();
        run_instr(ADD, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(LOAD, 1'b1, 1'b0, 1'b0, 0, 8, 1'b1);
        lit("pre_abort_retired", s_ret, 32'd1);
        lit("abort_retired", 32'(retired), 32'd0);
        lit("abort_state", 32'(state_o), 32'd0);
        lit("abort_rf_pulses", n_rf, 32'd0);

        run_instr(ADDI, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0);
        lit("after_abort_start_retired", s_ret, 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
